// File: rtl/uart_rx.sv
// uart_rx - oversampling serial receiver for the UART link.
//
// Frame format: start bit (0), 8 data bits LSB first, even parity bit,
// stop bit (1). The line is sampled at mid-bit using a bit-timing counter
// clocked by clk; CLKS_PER_BIT clk cycles make up one serial bit.
//
// Ports:
//   clk           system clock, all logic on the rising edge
//   rstn          synchronous active-low reset
//   rx_data_in    serial line, idle high
//   rx_data_out   last received byte (held until the next strobe)
//   rx_valid      one-cycle pulse when rx_data_out and the error flags update
//   rx_busy       high while a frame is in progress (state other than IDLE)
//   parity_error  last frame's parity did not match even parity
//   frame_error   last frame's stop bit was sampled as 0
//
// Build option:
//   RX_SYNC_EN  when defined, rx_data_in passes through a 2-flop synchronizer
//               (both flops reset to 1) before the FSM, adding 2 cycles of
//               latency. When undefined the line must be synchronous to clk.

module uart_rx #(
   parameter int CLKS_PER_BIT = 16,
   parameter int CW           = $clog2(CLKS_PER_BIT)
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       rx_data_in,
   output logic [7:0] rx_data_out,
   output logic       rx_valid,
   output logic       rx_busy,
   output logic       parity_error,
   output logic       frame_error
);

   // Terminal counts: half a bit to reach mid-start, a full bit thereafter.
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      WAIT_HIGH
   } state_t;

   logic s;

`ifdef RX_SYNC_EN
   logic sync_q1;
   logic sync_q2;

   // Reset to 1 so the idle line produces no false start after reset.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         sync_q1 <= 1'b1;
         sync_q2 <= 1'b1;
      end else begin
         sync_q1 <= rx_data_in;
         sync_q2 <= sync_q1;
      end
   end

   always_comb s = sync_q2;
`else
   always_comb s = rx_data_in;
`endif

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    idx_q, idx_d;
   logic [7:0]    sh_q, sh_d;
   logic          mis_q, mis_d;
   logic [7:0]    data_d;
   logic          valid_d;
   logic          busy_d;
   logic          pe_d;
   logic          fe_d;
   logic          at_half;
   logic          at_full;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      sh_d    = sh_q;
      mis_d   = mis_q;
      data_d  = rx_data_out;
      pe_d    = parity_error;
      fe_d    = frame_error;
      valid_d = 1'b0;
      at_half = (cnt_q == HALF_LAST);
      at_full = (cnt_q == FULL_LAST);

      case (state_q)
         IDLE: begin
            if (!s) begin
               state_d = START;
               cnt_d   = '0;
            end
         end

         START: begin
            if (at_half) begin
               cnt_d = '0;
               if (!s) begin
                  state_d = DATA;
                  idx_d   = '0;
               end else begin
                  // Line went high again before mid-start: a glitch.
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         DATA: begin
            if (at_full) begin
               cnt_d       = '0;
               sh_d[idx_q] = s;
               if (idx_q == 3'd7) begin
                  state_d = PARITY;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         PARITY: begin
            if (at_full) begin
               cnt_d   = '0;
               mis_d   = (^sh_q) ^ s;
               state_d = STOP;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         STOP: begin
            if (at_full) begin
               cnt_d   = '0;
               data_d  = sh_q;
               pe_d    = mis_q;
               fe_d    = ~s;
               valid_d = 1'b1;
               // Leaving at mid-stop lets a back-to-back start edge be seen.
               state_d = s ? IDLE : WAIT_HIGH;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         WAIT_HIGH: begin
            // Hold off until the line recovers so a break cannot retrigger.
            if (s) begin
               state_d = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         idx_q        <= '0;
         sh_q         <= '0;
         mis_q        <= 1'b0;
         rx_data_out  <= '0;
         rx_valid     <= 1'b0;
         rx_busy      <= 1'b0;
         parity_error <= 1'b0;
         frame_error  <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         sh_q         <= sh_d;
         mis_q        <= mis_d;
         rx_data_out  <= data_d;
         rx_valid     <= valid_d;
         rx_busy      <= busy_d;
         parity_error <= pe_d;
         frame_error  <= fe_d;
      end
   end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver for the UART link; it sits directly downstream of the transmit top.
- Consumes the transmitter's serial line: start bit (0), 8 data bits LSB first, even parity bit, stop bit (1).
- Oversamples the line, recovers the byte and checks parity and stop bit.
- Presents the byte with a one-cycle valid strobe and error flags.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per serial bit; legal range 4 to 65535.
- CW, $clog2(CLKS_PER_BIT), width of the bit-timing counter; derived, do not override.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rstn  input  1  synchronous active-low reset.
- rx_data_in  input  1  serial line; idle high.
- rx_data_out  output  8  last received byte.
- rx_valid  output  1  one-cycle pulse when rx_data_out and the error flags update.
- rx_busy  output  1  high while a frame is in progress (any state other than IDLE).
- parity_error  output  1  last frame's parity did not match even parity.
- frame_error  output  1  last frame's stop bit was sampled as 0.

Behaviour:
- Reset: one clock, rstn synchronous and active-low. While rstn=0 at a rising edge, all outputs and internal state clear on that edge:
  - state=IDLE, rx_data_out=8'h00
  - rx_valid, rx_busy, parity_error, frame_error = 0
  - counters = 0, shift register = 0
- Reset mid-frame aborts the frame; no rx_valid is produced.
- Sampled line `s`:
  - s = rx_data_in directly, or the synchronized version when RX_SYNC_EN is defined.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
- IDLE:
  - When s=0, go to START and clear the counter.
- START:
  - Count CLKS_PER_BIT/2 - 1 cycles (integer division), then sample mid-bit.
  - s=0: go to DATA, clear the counter and bit index.
  - s=1: glitch; return to IDLE with no strobe and no flag change.
- DATA:
  - Every CLKS_PER_BIT cycles, sample s into shift register bit [bit index], LSB first.
  - After bit index 7 is sampled, go to PARITY.
- PARITY:
  - After CLKS_PER_BIT cycles, sample s.
  - Even-parity rule: a mismatch is when (^data) XOR s = 1; the result is held for the strobe.
- STOP:
  - After CLKS_PER_BIT cycles, sample s.
  - On that same edge: rx_data_out <= shift register, parity_error <= mismatch, frame_error <= ~s.
  - rx_valid is high for exactly the following cycle.
  - s=1: go to IDLE. This is mid-stop-bit, so a back-to-back frame whose start edge follows the stop bit is received.
  - s=0: go to WAIT_HIGH.
- WAIT_HIGH:
  - Stay until s=1, then go to IDLE. Prevents a break or stuck-low line from retriggering frames.
- rx_valid is asserted on every completed frame, including errored ones.
- Error flags and rx_data_out hold their values until the next strobe.
- rx_busy = (state != IDLE), registered with the state.
- Latency: rx_valid rises floor(CLKS_PER_BIT/2) + 10*CLKS_PER_BIT cycles (+/-1 for start-edge detection) after the start-bit falling edge. Add 2 cycles when RX_SYNC_EN is defined.
- The counter never wraps inside a bit; it reloads to 0 at each sample point.

Optional Feature:
- Macro: RX_SYNC_EN.
- Defined: rx_data_in passes through a 2-flop synchronizer before the FSM.
  - Both flops reset to 1, so the idle line causes no false start after reset.
  - Adds 2 cycles of latency.
- Undefined: rx_data_in is used directly, for a same-clock-domain link such as a TX-to-RX loopback.
  - The caller guarantees the line is synchronous to clk.

Test Plan:
1. Byte 8'hA5, correct even parity 0, stop 1, CLKS_PER_BIT=16 -> single rx_valid pulse; rx_data_out=8'hA5, parity_error=0, frame_error=0; rx_busy low in the cycle after the strobe.
2. Byte 8'h01 sent with parity bit 0 (wrong) -> rx_valid; rx_data_out=8'h01, parity_error=1, frame_error=0.
3. Byte 8'h3C with stop bit forced 0, line held low for 40 cycles, then high -> rx_valid; frame_error=1; no second frame starts until the line has been high, rx_busy stays high through WAIT_HIGH.
4. 4-cycle low glitch on an idle line -> START samples 1, returns to IDLE; no rx_valid; flags unchanged.
5. Back-to-back frames 8'h55 then 8'hFF, no idle gap -> two rx_valid pulses, values 8'h55 then 8'hFF, no errors.
6. rstn=0 asserted at data bit 4 of a frame, released, then frame 8'h0F -> outputs zero during reset, no strobe for the aborted frame, next strobe carries 8'h0F. Repeat with RX_SYNC_EN defined and check the +2 cycle latency.
